// File: rtl/sha256_regs_pkg.sv
// Register map and bit positions of the sha256 core's bus, plus the sweep FSM state type.
// Shared by every controller that masters the core.
package sha256_regs_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_MODE_BIT    = 2;
    localparam int STATUS_VALID_BIT = 1;

    localparam logic MODE_SHA_224 = 1'b0;
    localparam logic MODE_SHA_256 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_SETTLE,
        ST_POLL,
        ST_CMP
    } sweep_state_t;

endpackage

// File: rtl/digest_cmp.sv
// Unsigned single-word magnitude compare of a digest word against a target word.
module digest_cmp #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            lt,
    output logic            eq,
    output logic            gt
);

    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Autonomous nonce sweep: loads a buffered block into the sha256 core once per nonce,
// polls for the digest and stops on the first digest strictly below the target.
module nonce_sweep_ctrl
    import sha256_regs_pkg::*;
#(
    parameter int BITS         = 32,
    parameter int BLOCK_WORDS  = 16,
    parameter int NONCE_IDX    = 3,
    parameter int NONCE_STEP   = 1,
    parameter int CMP_WORDS    = 2,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          blk_wr_en,
    input  logic [$clog2(BLOCK_WORDS)-1:0] blk_wr_addr,
    input  logic [BITS-1:0]               blk_wr_data,
    input  logic [BITS-1:0]               nonce_start,
    input  logic [BITS-1:0]               nonce_end,
    input  logic [CMP_WORDS*BITS-1:0]     target,
    input  logic                          mode,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          found,
    output logic                          done,
    output logic                          err,
    output logic [BITS-1:0]               found_nonce,
    output logic [BITS-1:0]               cur_nonce,
    output logic [BITS-1:0]               hash_count,
    output logic                          sha_cs,
    output logic                          sha_we,
    output logic [7:0]                    sha_address,
    output logic [BITS-1:0]               sha_write_data,
    input  logic [BITS-1:0]               sha_read_data
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int K_W   = (CMP_WORDS > 1) ? $clog2(CMP_WORDS) : 1;
    localparam int PC_W  = $clog2(POLL_TIMEOUT + 1);

    sweep_state_t               state_reg, state_next;
    logic [IDX_W-1:0]           load_idx_reg, load_idx_next;
    logic [K_W-1:0]             cmp_k_reg, cmp_k_next;
    logic [PC_W-1:0]            poll_cnt_reg, poll_cnt_next;
    logic [BITS-1:0]            cur_nonce_reg, cur_nonce_next;
    logic [BITS-1:0]            hash_count_reg, hash_count_next;
    logic [BITS-1:0]            found_nonce_reg, found_nonce_next;
    logic [BITS-1:0]            nonce_end_reg, nonce_end_next;
    logic [CMP_WORDS*BITS-1:0]  target_reg, target_next;
    logic                       mode_reg, mode_next;
    logic                       found_reg, found_next;
    logic                       done_reg, done_next;
    logic                       err_reg, err_next;

    // Block buffer with registered read; the read address runs one word ahead of
    // the word being written so the data is ready when LOAD reaches it.
    logic [BITS-1:0]  blk_mem [BLOCK_WORDS];
    logic [BITS-1:0]  blk_rd_reg;
    logic [IDX_W-1:0] rd_addr;
    logic             load_last;

    assign load_last = (load_idx_reg == IDX_W'(BLOCK_WORDS - 1));

    always_comb begin
        rd_addr = '0;
        if (state_reg == ST_LOAD && !load_last) begin
            rd_addr = load_idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (blk_wr_en && state_reg == ST_IDLE) begin
            blk_mem[blk_wr_addr] <= blk_wr_data;
        end
        blk_rd_reg <= blk_mem[rd_addr];
    end

    logic [BITS-1:0] target_words [CMP_WORDS];
    generate
        for (genvar gi = 0; gi < CMP_WORDS; gi++) begin : g_target_words
            assign target_words[gi] = target_reg[(CMP_WORDS-1-gi)*BITS +: BITS];
        end
    endgenerate

    logic cmp_lt, cmp_eq, cmp_gt, cmp_last;
    assign cmp_last = (cmp_k_reg == K_W'(CMP_WORDS - 1));

    digest_cmp #(.BITS(BITS)) u_digest_cmp (
        .a  (sha_read_data),
        .b  (target_words[cmp_k_reg]),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    // Bus strobes are a pure decode of the current state.
    always_comb begin
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = 8'h00;
        sha_write_data = '0;
        case (state_reg)
            ST_LOAD: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = ADDR_BLOCK0 + 8'(load_idx_reg);
                sha_write_data = (load_idx_reg == IDX_W'(NONCE_IDX)) ? cur_nonce_reg : blk_rd_reg;
            end
            ST_START: begin
                sha_cs                        = 1'b1;
                sha_we                        = 1'b1;
                sha_address                   = ADDR_CTRL;
                sha_write_data[CTRL_INIT_BIT] = 1'b1;
                sha_write_data[CTRL_MODE_BIT] = mode_reg;
            end
            ST_POLL: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_STATUS;
            end
            ST_CMP: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_DIGEST0 + 8'(cmp_k_reg);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        load_idx_next    = load_idx_reg;
        cmp_k_next       = cmp_k_reg;
        poll_cnt_next    = poll_cnt_reg;
        cur_nonce_next   = cur_nonce_reg;
        hash_count_next  = hash_count_reg;
        found_nonce_next = found_nonce_reg;
        nonce_end_next   = nonce_end_reg;
        target_next      = target_reg;
        mode_next        = mode_reg;
        found_next       = found_reg;
        done_next        = done_reg;
        err_next         = err_reg;

        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        nonce_end_next  = nonce_end;
                        target_next     = target;
                        mode_next       = mode;
                        cur_nonce_next  = nonce_start;
                        hash_count_next = '0;
                        found_next      = 1'b0;
                        done_next       = 1'b0;
                        err_next        = 1'b0;
                        load_idx_next   = '0;
                        state_next      = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_idx_next = load_idx_reg + IDX_W'(1);
                    if (load_last) begin
                        load_idx_next = '0;
                        state_next    = ST_START;
                    end
                end
                ST_START: state_next = ST_SETTLE;
                ST_SETTLE: begin
                    poll_cnt_next = '0;
                    state_next    = ST_POLL;
                end
                ST_POLL: begin
                    if (sha_read_data[STATUS_VALID_BIT]) begin
                        cmp_k_next = '0;
                        state_next = ST_CMP;
                    end else if (poll_cnt_reg == PC_W'(POLL_TIMEOUT - 1)) begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        poll_cnt_next = poll_cnt_reg + PC_W'(1);
                    end
                end
                ST_CMP: begin
                    if (cmp_lt) begin
                        hash_count_next  = hash_count_reg + BITS'(1);
                        found_next       = 1'b1;
                        found_nonce_next = cur_nonce_reg;
                        state_next       = ST_IDLE;
                    end else if (cmp_gt || (cmp_eq && cmp_last)) begin
                        // An all-equal digest is a miss: the hit rule is strictly-less.
                        hash_count_next = hash_count_reg + BITS'(1);
                        if (cur_nonce_reg == nonce_end_reg) begin
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            cur_nonce_next = cur_nonce_reg + BITS'(NONCE_STEP);
                            load_idx_next  = '0;
                            state_next     = ST_LOAD;
                        end
                    end else begin
                        cmp_k_next = cmp_k_reg + K_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            load_idx_reg    <= '0;
            cmp_k_reg       <= '0;
            poll_cnt_reg    <= '0;
            cur_nonce_reg   <= '0;
            hash_count_reg  <= '0;
            found_nonce_reg <= '0;
            nonce_end_reg   <= '0;
            target_reg      <= '0;
            mode_reg        <= 1'b0;
            found_reg       <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            load_idx_reg    <= load_idx_next;
            cmp_k_reg       <= cmp_k_next;
            poll_cnt_reg    <= poll_cnt_next;
            cur_nonce_reg   <= cur_nonce_next;
            hash_count_reg  <= hash_count_next;
            found_nonce_reg <= found_nonce_next;
            nonce_end_reg   <= nonce_end_next;
            target_reg      <= target_next;
            mode_reg        <= mode_next;
            found_reg       <= found_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign found       = found_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign found_nonce = found_nonce_reg;
    assign cur_nonce   = cur_nonce_reg;
    assign hash_count  = hash_count_reg;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: a behavioural sha256 core on the bus and a
// range-walking reference model that predicts each sweep's outcome.
module tb_nonce_sweep_ctrl;

    logic        clk;
    logic        reset_n;
    logic        blk_wr_en;
    logic [3:0]  blk_wr_addr;
    logic [31:0] blk_wr_data;
    logic [31:0] nonce_start;
    logic [31:0] nonce_end;
    logic [63:0] target;
    logic        mode;
    logic        start;
    logic        abort;
    logic        busy, found, done, err;
    logic [31:0] found_nonce, cur_nonce, hash_count;
    logic        sha_cs, sha_we;
    logic [7:0]  sha_address;
    logic [31:0] sha_write_data;
    logic [31:0] sha_read_data;

    nonce_sweep_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .blk_wr_en      (blk_wr_en),
        .blk_wr_addr    (blk_wr_addr),
        .blk_wr_data    (blk_wr_data),
        .nonce_start    (nonce_start),
        .nonce_end      (nonce_end),
        .target         (target),
        .mode           (mode),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .found          (found),
        .done           (done),
        .err            (err),
        .found_nonce    (found_nonce),
        .cur_nonce      (cur_nonce),
        .hash_count     (hash_count),
        .sha_cs         (sha_cs),
        .sha_we         (sha_we),
        .sha_address    (sha_address),
        .sha_write_data (sha_write_data),
        .sha_read_data  (sha_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Digest rule of the modelled core: one special nonce may get its own digest.
    logic [63:0] default_dig, special_dig;
    logic [31:0] special_nonce;
    bit          special_en  = 0;
    bit          never_valid = 0;

    function automatic logic [63:0] dig_of(input logic [31:0] n);
        return (special_en && n == special_nonce) ? special_dig : default_dig;
    endfunction

    logic [31:0] blk_ref  [16];
    logic [31:0] blk_seen [16];
    logic [31:0] seen_q [$];
    logic [31:0] ctrl_q [$];
    logic [63:0] cur_dig = '0;
    logic        core_valid = 1'b0;
    bit          core_pending = 0;
    int          core_delay = 0;
    int          blk_bad = 0;
    int          status_reads = 0;

    always @(negedge clk) begin
        if (sha_cs && !sha_we && sha_address == 8'h09) status_reads++;
        if (sha_cs && sha_we) begin
            if (sha_address >= 8'h10 && sha_address < 8'h20) begin
                blk_seen[sha_address[3:0]] = sha_write_data;
            end else if (sha_address == 8'h08 && sha_write_data[0]) begin
                for (int i = 0; i < 16; i++)
                    if (i != 3 && blk_seen[i] !== blk_ref[i]) blk_bad++;
                seen_q.push_back(blk_seen[3]);
                ctrl_q.push_back(sha_write_data);
                cur_dig      = dig_of(blk_seen[3]);
                core_valid   = 1'b0;
                core_pending = 1;
                core_delay   = $urandom_range(0, 4);
            end
        end else if (core_pending) begin
            if (core_delay > 0) core_delay--;
            else if (!never_valid) begin
                core_valid   = 1'b1;
                core_pending = 0;
            end
        end
    end

    always_comb begin
        sha_read_data = 32'h0;
        if (sha_address == 8'h09)      sha_read_data[1] = core_valid;
        else if (sha_address == 8'h20) sha_read_data = cur_dig[63:32];
        else if (sha_address == 8'h21) sha_read_data = cur_dig[31:0];
    end

    // Reference: walk the range as plain numbers, 64-bit digest vs 64-bit target.
    logic [31:0] exp_q [$];
    bit          exp_found, exp_done;
    logic [31:0] exp_fn, exp_last;
    int          exp_hc;

    task automatic model_sweep(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t);
        logic [31:0] n = s;
        exp_q.delete();
        exp_found = 0; exp_done = 0; exp_hc = 0; exp_fn = '0; exp_last = s;
        for (int it = 0; it < 64; it++) begin
            exp_q.push_back(n);
            exp_hc++;
            exp_last = n;
            if (dig_of(n) < t) begin exp_found = 1; exp_fn = n; break; end
            if (n == e) begin exp_done = 1; break; end
            n = n + 32'd1;
        end
    endtask

    task automatic load_block();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            blk_ref[i]  = $urandom;
            blk_wr_en   = 1'b1;
            blk_wr_addr = 4'(i);
            blk_wr_data = blk_ref[i];
        end
        @(negedge clk);
        blk_wr_en = 1'b0;
    endtask

    task automatic drive_start(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t, input logic m);
        seen_q.delete();
        ctrl_q.delete();
        blk_bad = 0;
        status_reads = 0;
        @(negedge clk);
        nonce_start = s; nonce_end = e; target = t; mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 20000) begin @(negedge clk); cyc++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sweep_timeout busy=%0d after %0d cycles, want 0", busy, cyc); end
        $display("sweep start=%h end=%h found=%0d done=%0d err=%0d hc=%0d cur=%h", nonce_start, nonce_end, found, done, err, hash_count, cur_nonce);
    endtask

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t, input logic m);
        model_sweep(s, e, t);
        drive_start(s, e, t, m);
        wait_idle();
    endtask

    task automatic test_reset_powerup();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, found, done, err, sha_cs, sha_we} !== 6'b0 || found_nonce !== 0 || cur_nonce !== 0 || hash_count !== 0 || sha_address !== 0 || sha_write_data !== 0) begin
            errors++;
            $display("FAIL reset_powerup flags=%b fn=%h cur=%h hc=%h addr=%h, want all 0", {busy, found, done, err, sha_cs, sha_we}, found_nonce, cur_nonce, hash_count, sha_address);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_hit();
        default_dig = {32'h12345678, 32'h12345678};
        special_en = 0;
        run_sweep(32'h10, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        checks++;
        if (found !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_flags found=%0d done=%0d, want 1 0", found, done); end
        checks++;
        if (found_nonce !== 32'h10) begin errors++; $display("FAIL single_found_nonce got %h want 00000010", found_nonce); end
        checks++;
        if (hash_count !== 32'd1) begin errors++; $display("FAIL single_hash_count got %0d want 1", hash_count); end
        checks++;
        if (seen_q.size() != 1 || seen_q[0] !== 32'h10) begin errors++; $display("FAIL single_addr13 loads=%0d first=%h want 1 x 00000010", seen_q.size(), seen_q.size() ? seen_q[0] : 32'h0); end
        checks++;
        if (blk_bad != 0 || ctrl_q.size() != 1 || ctrl_q[0] !== 32'h5) begin errors++; $display("FAIL single_block bad_words=%0d ctrl=%h want 0 and 00000005", blk_bad, ctrl_q.size() ? ctrl_q[0] : 32'h0); end
    endtask

    task automatic test_range_miss(input logic [31:0] s, input logic [31:0] e, input string tag);
        default_dig = {$urandom, $urandom};
        special_en = 0;
        run_sweep(s, e, 64'h0, 1'b1);
        checks++;
        if (done !== 1'b1 || found !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL %s_flags done=%0d found=%0d err=%0d want 1 0 0", tag, done, found, err); end
        checks++;
        if (hash_count !== 32'd3) begin errors++; $display("FAIL %s_hash_count got %0d want 3", tag, hash_count); end
        checks++;
        if (seen_q.size() != 3) begin errors++; $display("FAIL %s_nonce_count got %0d want 3", tag, seen_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen_q[i] !== s + 32'(i)) begin errors++; $display("FAIL %s_nonce%0d got %h want %h", tag, i, seen_q[i], s + 32'(i)); end
            end
        end
    endtask

    task automatic test_cmp_depth();
        logic [63:0] t = {32'hA5A5_0000, 32'h0000_1000};
        special_en = 0;
        default_dig = {32'hA5A5_0000, 32'h0000_0FFF};
        run_sweep(32'h77, 32'h78, t, 1'b0);
        checks++;
        if (found !== 1'b1 || hash_count !== 32'd1 || found_nonce !== 32'h77) begin errors++; $display("FAIL cmp_k1_hit found=%0d hc=%0d fn=%h want 1 1 00000077", found, hash_count, found_nonce); end
        checks++;
        if (ctrl_q.size() != 1 || ctrl_q[0] !== 32'h1) begin errors++; $display("FAIL cmp_mode224_ctrl got %h want 00000001", ctrl_q.size() ? ctrl_q[0] : 32'h0); end
        default_dig = t;
        run_sweep(32'h77, 32'h78, t, 1'b0);
        checks++;
        if (found !== 1'b0 || done !== 1'b1 || hash_count !== 32'd2) begin errors++; $display("FAIL cmp_equal_miss found=%0d done=%0d hc=%0d want 0 1 2", found, done, hash_count); end
        default_dig = {32'hA5A4_FFFF, 32'hFFFF_FFFF};
        run_sweep(32'h9, 32'h9, t, 1'b1);
        checks++;
        if (found !== 1'b1 || found_nonce !== 32'h9) begin errors++; $display("FAIL cmp_k0_hit found=%0d fn=%h want 1 00000009", found, found_nonce); end
    endtask

    task automatic test_reset_mid_poll();
        never_valid = 1;
        drive_start(32'h55, 32'h60, 64'h1, 1'b1);
        for (int i = 0; i < 100 && status_reads < 5; i++) @(negedge clk);
        checks++;
        if (status_reads < 5) begin errors++; $display("FAIL reset_reach_poll status_reads=%0d want >=5", status_reads); end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, found, done, err, sha_cs, sha_we} !== 6'b0 || found_nonce !== 0 || cur_nonce !== 0 || hash_count !== 0 || sha_address !== 0) begin
            errors++;
            $display("FAIL reset_mid_poll flags=%b fn=%h cur=%h hc=%h addr=%h, want all 0", {busy, found, done, err, sha_cs, sha_we}, found_nonce, cur_nonce, hash_count, sha_address);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sha_cs !== 1'b0) begin errors++; $display("FAIL reset_release busy=%0d cs=%0d want 0 0", busy, sha_cs); end
        never_valid = 0;
    endtask

    task automatic test_timeout();
        never_valid = 1;
        default_dig = 64'h0;
        drive_start(32'h40, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_idle();
        checks++;
        if (err !== 1'b1 || found !== 1'b0 || done !== 1'b0 || hash_count !== 0) begin errors++; $display("FAIL timeout_flags err=%0d found=%0d done=%0d hc=%0d want 1 0 0 0", err, found, done, hash_count); end
        checks++;
        if (status_reads != 1024) begin errors++; $display("FAIL timeout_polls got %0d want 1024", status_reads); end
        never_valid = 0;
    endtask

    task automatic test_abort();
        default_dig = 64'hFFFF_FFFF_FFFF_FFFF;
        special_en = 0;
        drive_start(32'h100, 32'h200, 64'h10, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (!(sha_cs && sha_we && sha_address >= 8'h10 && sha_address < 8'h20)) begin errors++; $display("FAIL abort_in_load cs=%0d we=%0d addr=%h want block write", sha_cs, sha_we, sha_address); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || sha_cs !== 1'b0 || {found, done, err} !== 3'b0 || cur_nonce !== 32'h100 || hash_count !== 0) begin
            errors++;
            $display("FAIL abort_load busy=%0d cs=%0d flags=%b cur=%h hc=%0d want 0 0 000 00000100 0", busy, sha_cs, {found, done, err}, cur_nonce, hash_count);
        end
        @(negedge clk);
        nonce_start = 32'h300; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cur_nonce !== 32'h100) begin errors++; $display("FAIL abort_wins_start busy=%0d cur=%h want 0 00000100", busy, cur_nonce); end
    endtask

    task automatic test_back_to_back();
        special_en = 0;
        default_dig = 64'h8;
        model_sweep(32'h5, 32'h6, 64'h0);
        drive_start(32'h5, 32'h6, 64'h0, 1'b1);
        repeat (2) @(negedge clk);
        nonce_start = 32'h999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        checks++;
        if (seen_q.size() != 2 || seen_q[0] !== 32'h5 || seen_q[1] !== 32'h6 || done !== 1'b1 || hash_count !== 32'd2) begin
            errors++;
            $display("FAIL start_while_busy loads=%0d first=%h done=%0d hc=%0d want 2 00000005 1 2", seen_q.size(), seen_q.size() ? seen_q[0] : 32'h0, done, hash_count);
        end
        special_en = 1; special_nonce = 32'h21; special_dig = 64'h0;
        run_sweep(32'h20, 32'h23, 64'h1, 1'b1);
        checks++;
        if (found !== 1'b1 || found_nonce !== 32'h21 || hash_count !== 32'd2 || cur_nonce !== 32'h21) begin
            errors++;
            $display("FAIL back_to_back found=%0d fn=%h hc=%0d cur=%h want 1 00000021 2 00000021", found, found_nonce, hash_count, cur_nonce);
        end
        special_en = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            logic [31:0] s, e;
            logic [63:0] t;
            logic        m;
            if (it % 4 == 0) load_block();
            s = (it % 5 == 0) ? 32'hFFFF_FFFD : $urandom;
            e = s + 32'($urandom_range(0, 5));
            t = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            default_dig = t + 64'($urandom_range(0, 3));
            special_en = ($urandom_range(0, 1) == 1);
            special_nonce = s + 32'($urandom_range(0, 5));
            special_dig = t - 64'($urandom_range(1, 3));
            run_sweep(s, e, t, m);
            checks++;
            if (found !== exp_found || done !== exp_done || err !== 1'b0) begin errors++; $display("FAIL rand%0d_flags found=%0d done=%0d err=%0d want %0d %0d 0", it, found, done, err, exp_found, exp_done); end
            checks++;
            if (hash_count !== 32'(exp_hc) || cur_nonce !== exp_last) begin errors++; $display("FAIL rand%0d_count hc=%0d cur=%h want %0d %h", it, hash_count, cur_nonce, exp_hc, exp_last); end
            if (exp_found) begin
                checks++;
                if (found_nonce !== exp_fn) begin errors++; $display("FAIL rand%0d_found_nonce got %h want %h", it, found_nonce, exp_fn); end
            end
            checks++;
            if (seen_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_loads got %0d want %0d", it, seen_q.size(), exp_q.size()); end
            else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (seen_q[i] !== exp_q[i] || ctrl_q[i] !== {29'b0, m, 2'b01}) begin
                        errors++;
                        $display("FAIL rand%0d_load%0d nonce=%h ctrl=%h want %h %h", it, i, seen_q[i], ctrl_q[i], exp_q[i], {29'b0, m, 2'b01});
                    end
                end
            end
            checks++;
            if (blk_bad != 0) begin errors++; $display("FAIL rand%0d_block bad_words=%0d want 0", it, blk_bad); end
        end
    endtask

    initial begin
        reset_n = 1'b0; blk_wr_en = 1'b0; blk_wr_addr = '0; blk_wr_data = '0;
        nonce_start = '0; nonce_end = '0; target = '0; mode = 1'b1;
        start = 1'b0; abort = 1'b0;
        default_dig = '0; special_dig = '0; special_nonce = '0;
        test_reset_powerup();
        load_block();
        test_single_hit();
        test_range_miss(32'h5, 32'h7, "range");
        test_range_miss(32'hFFFF_FFFF, 32'h1, "wrap");
        test_cmp_depth();
        test_reset_mid_poll();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
